instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer for the 12-bit accumulator ISA (load/store/sub/add/disp).
- Owns the program counter and fetches from instruction memory.
- Latches the instruction for the decoder and issues one commit strobe per instruction to the datapath.
- Supports free-run and single-step modes, a timed display hold for `disp`, and halts after the last program word.
- Sits between the board controls/instruction memory and the existing decoder/datapath; the datapath gates register-file and data-memory writes with `exec_en`.

## Interface
Parameters:
- PC_W, 4, program counter / instruction memory address width
- PROG_LAST, 15, address of final instruction; sequencer halts after executing it
- DISP_HOLD, 4, cycles (≥1) the `disp` result is held before advancing

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- run  in  1  level; free-run while high
- step  in  1  single-step request; rising edge detected internally
- im_addr  out  PC_W  instruction memory address (= pc)
- im_data  in  12  instruction memory read data, combinational from im_addr
- instr  out  12  latched instruction to decoder/datapath
- exec_en  out  1  one-cycle commit strobe for a legal instruction
- disp_hold  out  1  high while display hold is active
- pc  out  PC_W  current program counter
- halted  out  1  high in HALT
- illegal  out  1  sticky; set on opcode 100, 101 or 111

## Operation
- Opcode is `instr[11:9]`.
  - Legal opcodes: 000 load, 001 store, 010 sub, 011 add, 110 disp.
  - All other opcodes are illegal.
- Step edge: `step_pulse = step & ~step_q`, where `step_q` is a register reset to 0.
- States: IDLE, FETCH, EXEC, DISP, HALT. Reset state is IDLE.
- IDLE:
  - If `run | step_pulse`, go to FETCH; otherwise stay.
  - `run` and `step_pulse` together behave the same as `run` alone.
- FETCH: `instr <= im_data`; go to EXEC.
- EXEC:
  - `exec_en = 1` iff the opcode is legal.
  - An illegal opcode sets `illegal`, is treated as a NOP, and `pc` still advances.
  - If opcode is disp: load hold counter with DISP_HOLD-1 and go to DISP.
  - Otherwise, advance.
- DISP:
  - `disp_hold = 1`; counter decrements each cycle.
  - When counter = 0, advance.
- Advance:
  - If `pc == PROG_LAST`, go to HALT and leave `pc` unchanged.
  - Else `pc <= pc + 1` (wraps modulo 2^PC_W), then go to FETCH if `run` is high, else IDLE.
- HALT: `halted = 1`; `run` and `step` are ignored until reset.
- Ignored requests:
  - `step_pulse` outside IDLE is dropped (not queued).
  - `run` falling mid-instruction lets the current instruction complete.
- Reset (any state, including mid-DISP or mid-EXEC):
  - State goes to IDLE.
  - `pc`, `instr`, hold counter, `step_q` and `illegal` are cleared to 0.
  - `exec_en`, `disp_hold` and `halted` are 0.

## Timing
- Reset values: `im_addr`=0, `pc`=0, `instr`=0, `exec_en`=0, `disp_hold`=0, `halted`=0, `illegal`=0.
- `exec_en`, `disp_hold` and `halted` are decoded from registered state only (glitch-free, no combinational path from inputs).
- `im_addr` equals `pc` (registered).
- Start latency: `run` high sampled at edge N means FETCH in cycle N+1 and EXEC in cycle N+2.
- Free-run throughput:
  - Non-disp instruction: 2 cycles, so `exec_en` pulses every 2nd cycle.
  - disp: 2 + DISP_HOLD cycles.
- `pc` updates on the edge that leaves EXEC (non-disp) or leaves the last DISP cycle.
- `run` is sampled on that same edge.
- Single step: one `step` rising edge yields exactly one EXEC, then IDLE. Holding `step` high yields no further instructions.
- `illegal` sets on the edge leaving EXEC and stays set until reset.

## Test plan
1. Reset:
   - Stimulus: hold `reset` 2 cycles with random `run`/`step`.
   - Response: all outputs 0, no `exec_en`; releasing with `run`=0 stays IDLE for 10 cycles.
2. Free-run:
   - Stimulus: program `0x600`, `0x400`, `0x000`, `0x200` at addresses 0-3; `run`=1 from cycle 0.
   - Response: `exec_en` high in cycles 2, 4, 6, 8 with `instr` matching each word.
   - Response: `pc` is 1, 2, 3, 4 after each.
3. Display hold:
   - Stimulus: DISP_HOLD=4, `0xC00` at address 0, `0x600` at address 1, `run`=1.
   - Response: `exec_en` at cycle 2, `disp_hold` cycles 3-6, next `exec_en` at cycle 8.
4. Single step:
   - Stimulus: two 1-cycle `step` pulses 10 cycles apart, then `step` held high for 20 cycles.
   - Response: exactly 3 `exec_en` pulses; `pc` 0→1→2→3.
   - Response: a `step` pulse during EXEC is dropped.
5. Halt and illegal:
   - Stimulus: PROG_LAST=2, word 1 = `0x800`, `run`=1.
   - Response: no `exec_en` at cycle 4, `illegal`=1 from cycle 5.
   - Response: `halted`=1 after the third EXEC (cycle 6) with `pc`=2, no further `exec_en`.
   - Response: `reset` clears `halted` and `illegal`.
6. Reset mid-DISP:
   - Stimulus: assert `reset` in the second `disp_hold` cycle.
   - Response: next cycle IDLE, `pc`=0, `disp_hold`=0; rerun restarts from address 0.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle sequencer for the 12-bit accumulator ISA
// (load/store/sub/add/disp). It owns the program counter, fetches from a
// combinational instruction memory, latches the instruction for the decoder,
// and issues one commit strobe per legal instruction to the datapath.
//
// Ports
//   i_clk        system clock, all state on rising edge
//   i_reset      synchronous, active-high reset
//   i_run        level; free-run while high
//   i_step       single-step request; rising edge detected internally
//   o_im_addr    instruction memory address (= o_pc)
//   i_im_data    instruction memory read data (combinational from o_im_addr)
//   o_instr      latched instruction for decoder/datapath
//   o_exec_en    one-cycle commit strobe for a legal instruction
//   o_disp_hold  high while the display hold is active
//   o_pc         current program counter
//   o_halted     high in HALT
//   o_illegal    sticky flag, set on opcode 100, 101 or 111
//   o_dbg_state  current FSM state encoding (state_t)
//
// Strobe protocol: o_exec_en is a single-cycle, unconditional commit strobe.
// There is no back-pressure; the datapath must accept the write in the cycle
// o_exec_en is high, and o_instr is stable for that whole cycle.
// o_exec_en, o_disp_hold and o_halted decode registered state only.
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_W      = 4,
  parameter int PROG_LAST = 15,
  parameter int DISP_HOLD = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_run,
  input  logic            i_step,
  output logic [PC_W-1:0] o_im_addr,
  input  logic [11:0]     i_im_data,
  output logic [11:0]     o_instr,
  output logic            o_exec_en,
  output logic            o_disp_hold,
  output logic [PC_W-1:0] o_pc,
  output logic            o_halted,
  output logic            o_illegal,
  output logic [2:0]      o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DISP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int CNT_W = (DISP_HOLD > 1) ? $clog2(DISP_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(DISP_HOLD - 1);
  localparam logic [PC_W-1:0]  LAST_PC   = PC_W'(PROG_LAST);

  state_t           r_state;
  logic [PC_W-1:0]  r_pc;
  logic [11:0]      r_instr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_step_q;
  logic             r_illegal;

  state_t           w_state_nxt;
  logic [2:0]       w_opcode;
  logic             w_legal;
  logic             w_is_disp;
  logic             w_step_pulse;
  logic             w_advance;
  logic             w_at_last;

  assign w_opcode     = r_instr[11:9];
  assign w_step_pulse = i_step & ~r_step_q;
  assign w_at_last    = (r_pc == LAST_PC);
  assign w_is_disp    = (w_opcode == 3'b110);

  always_comb begin
    w_legal = 1'b0;
    case (w_opcode)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b110: w_legal = 1'b1;
      default:                                w_legal = 1'b0;
    endcase
  end

  // Next-state logic. w_advance marks the single cycle in which the current
  // instruction retires; pc update, halt decision and run sampling all
  // happen on the edge that ends that cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_run || w_step_pulse) w_state_nxt = S_FETCH;
      end
      S_FETCH: w_state_nxt = S_EXEC;
      S_EXEC: begin
        // Illegal opcodes fall through here as a NOP and still advance.
        if (w_is_disp) w_state_nxt = S_DISP;
        else           w_advance   = 1'b1;
      end
      S_DISP: begin
        if (r_cnt == '0) w_advance = 1'b1;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_advance) begin
      if (w_at_last)  w_state_nxt = S_HALT;
      else if (i_run) w_state_nxt = S_FETCH;
      else            w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_instr   <= '0;
      r_cnt     <= '0;
      r_step_q  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_step_q <= i_step;
      if (r_state == S_FETCH) r_instr <= i_im_data;
      if (r_state == S_EXEC && w_is_disp)
        r_cnt <= HOLD_LOAD;
      else if (r_state == S_DISP && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
      if (r_state == S_EXEC && !w_legal) r_illegal <= 1'b1;
      // pc stays on the last address when the program ends.
      if (w_advance && !w_at_last) r_pc <= r_pc + 1'b1;
    end
  end

  assign o_im_addr   = r_pc;
  assign o_pc        = r_pc;
  assign o_instr     = r_instr;
  assign o_exec_en   = (r_state == S_EXEC) && w_legal;
  assign o_disp_hold = (r_state == S_DISP);
  assign o_halted    = (r_state == S_HALT);
  assign o_illegal   = r_illegal;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. Two instances share the clock: u_dut
// with default parameters and u_dut_h with PROG_LAST=2 for the halt case.
// Inputs change on the falling edge, outputs are sampled on the falling
// edge. "Cycle c" is the clock period that follows the c-th rising edge
// after reset is released; cycle 0 is the first period with reset low.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_EXEC  = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, step;
  logic [3:0]  im_addr;
  logic [11:0] im_data, instr;
  logic        exec_en, disp_hold, halted, illegal;
  logic [3:0]  pc;
  logic [2:0]  dbg_state;
  logic [11:0] mem [16];

  logic        reset_h, run_h, step_h;
  logic [3:0]  im_addr_h;
  logic [11:0] im_data_h, instr_h;
  logic        exec_en_h, disp_hold_h, halted_h, illegal_h;
  logic [3:0]  pc_h;
  logic [2:0]  dbg_state_h;
  logic [11:0] mem_h [16];

  assign im_data   = mem[im_addr];
  assign im_data_h = mem_h[im_addr_h];

  instr_sequencer #(.PC_W(4), .PROG_LAST(15), .DISP_HOLD(4)) u_dut (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_step(step),
    .o_im_addr(im_addr), .i_im_data(im_data), .o_instr(instr),
    .o_exec_en(exec_en), .o_disp_hold(disp_hold), .o_pc(pc),
    .o_halted(halted), .o_illegal(illegal), .o_dbg_state(dbg_state)
  );

  instr_sequencer #(.PC_W(4), .PROG_LAST(2), .DISP_HOLD(4)) u_dut_h (
    .i_clk(clk), .i_reset(reset_h), .i_run(run_h), .i_step(step_h),
    .o_im_addr(im_addr_h), .i_im_data(im_data_h), .o_instr(instr_h),
    .o_exec_en(exec_en_h), .o_disp_hold(disp_hold_h), .o_pc(pc_h),
    .o_halted(halted_h), .o_illegal(illegal_h), .o_dbg_state(dbg_state_h)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Every commit strobe of u_dut must match the next queued instruction.
  task automatic sb_on_exec();
    if (exec_en) begin
      if (exp_q.size() == 0) check("sb_extra_exec", 32'(instr), 32'hFFF);
      else                   check("sb_instr", 32'(instr), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 12'h000;
      mem_h[i] = 12'h000;
    end
  endtask

  // Two reset edges with random run/step, then release; returns in cycle 0.
  task automatic do_reset(input logic run_after);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      run  = 1'($urandom_range(0, 1));
      step = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    reset = 1'b0;
    run   = run_after;
    step  = 1'b0;
  endtask

  task automatic do_reset_h(input logic run_after);
    reset_h = 1'b1;
    run_h   = 1'b0;
    step_h  = 1'b0;
    repeat (2) @(negedge clk);
    reset_h = 1'b0;
    run_h   = run_after;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; run = 1'b0; step = 1'b0;
    reset_h = 1'b1; run_h = 1'b0; step_h = 1'b0;
    clear_mem();
    @(negedge clk);

    // ---- 1: reset values, idle without run ----
    do_reset(1'b0);
    check("rst_im_addr",   32'(im_addr),   32'h0);
    check("rst_pc",        32'(pc),        32'h0);
    check("rst_instr",     32'(instr),     32'h0);
    check("rst_exec_en",   32'(exec_en),   32'h0);
    check("rst_disp_hold", 32'(disp_hold), 32'h0);
    check("rst_halted",    32'(halted),    32'h0);
    check("rst_illegal",   32'(illegal),   32'h0);
    check("rst_state",     32'(dbg_state), 32'(ST_IDLE));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("idle_exec_en", 32'(exec_en),   32'h0);
      check("idle_state",   32'(dbg_state), 32'(ST_IDLE));
    end

    // ---- 2: free-run, exec_en every 2nd cycle ----
    clear_mem();
    mem[0] = 12'h600; mem[1] = 12'h400; mem[2] = 12'h000; mem[3] = 12'h200;
    exp_q = {12'h600, 12'h400, 12'h000, 12'h200, 12'h000};
    do_reset(1'b1);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check("fr_exec_en", 32'(exec_en), 32'((c % 2 == 0) ? 1 : 0));
      sb_on_exec();
      if (c % 2 == 1 && c >= 3) begin
        check("fr_pc",      32'(pc),      32'((c - 1) / 2));
        check("fr_im_addr", 32'(im_addr), 32'((c - 1) / 2));
      end
      if (c == 9) run = 1'b0;   // fifth instruction still completes
    end
    @(negedge clk);
    check("fr_stop_state", 32'(dbg_state), 32'(ST_IDLE));
    check("fr_stop_pc",    32'(pc),        32'h5);
    check("fr_sb_empty",   32'(exp_q.size()), 32'h0);

    // ---- 3: display hold ----
    clear_mem();
    mem[0] = 12'hC00; mem[1] = 12'h600;
    exp_q = {12'hC00, 12'h600};
    do_reset(1'b1);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check("dh_exec_en",   32'(exec_en),   32'((c == 2 || c == 8) ? 1 : 0));
      check("dh_disp_hold", 32'(disp_hold), 32'((c >= 3 && c <= 6) ? 1 : 0));
      sb_on_exec();
      if (c == 3) check("dh_instr", 32'(instr), 32'hC00);
      if (c == 7) check("dh_pc7",   32'(pc),    32'h1);
      if (c == 9) begin
        check("dh_pc9",    32'(pc),        32'h2);
        check("dh_state9", 32'(dbg_state), 32'(ST_IDLE));
      end
      if (c == 8) run = 1'b0;
    end
    check("dh_sb_empty", 32'(exp_q.size()), 32'h0);

    // ---- 4: single step, dropped pulse, held step ----
    clear_mem();
    mem[0] = 12'h600; mem[1] = 12'h400; mem[2] = 12'h000; mem[3] = 12'h200;
    exp_q = {12'h600, 12'h400, 12'h000};
    do_reset(1'b0);
    step = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      check("ss_exec_en", 32'(exec_en), 32'((c == 2 || c == 12 || c == 22) ? 1 : 0));
      check("ss_pc", 32'(pc), 32'((c >= 23) ? 3 : (c >= 13) ? 2 : (c >= 3) ? 1 : 0));
      sb_on_exec();
      // c==2 is the EXEC cycle: that pulse must be dropped.
      step = (c == 2) || (c == 10) || (c >= 20 && c < 40);
    end
    check("ss_state_end", 32'(dbg_state), 32'(ST_IDLE));
    check("ss_sb_empty",  32'(exp_q.size()), 32'h0);

    // ---- 5: halt after PROG_LAST, illegal opcode ----
    clear_mem();
    mem_h[0] = 12'h600; mem_h[1] = 12'h800; mem_h[2] = 12'h400;
    do_reset_h(1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check("h_exec_en", 32'(exec_en_h), 32'((c == 2 || c == 6) ? 1 : 0));
      check("h_illegal", 32'(illegal_h), 32'((c >= 5) ? 1 : 0));
      check("h_halted",  32'(halted_h),  32'((c >= 7) ? 1 : 0));
      check("h_pc",      32'(pc_h),      32'((c >= 5) ? 2 : (c >= 3) ? 1 : 0));
      step_h = (c == 9);
    end
    reset_h = 1'b1;
    @(negedge clk);
    check("h_rst_halted",  32'(halted_h),    32'h0);
    check("h_rst_illegal", 32'(illegal_h),   32'h0);
    check("h_rst_pc",      32'(pc_h),        32'h0);
    check("h_rst_state",   32'(dbg_state_h), 32'(ST_IDLE));
    reset_h = 1'b0; run_h = 1'b0;

    // ---- 6: reset in the middle of a display hold ----
    clear_mem();
    mem[0] = 12'hC00; mem[1] = 12'h600;
    exp_q.delete();
    do_reset(1'b1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("rd_disp_hold", 32'(disp_hold), 32'((c >= 3) ? 1 : 0));
    end
    reset = 1'b1;               // second hold cycle
    @(negedge clk);
    check("rd_state",     32'(dbg_state), 32'(ST_IDLE));
    check("rd_pc",        32'(pc),        32'h0);
    check("rd_disp_hold", 32'(disp_hold), 32'h0);
    check("rd_instr",     32'(instr),     32'h0);
    reset = 1'b0; run = 1'b1;
    @(negedge clk);
    check("rd_re_fetch",   32'(dbg_state), 32'(ST_FETCH));
    check("rd_re_im_addr", 32'(im_addr),   32'h0);
    @(negedge clk);
    check("rd_re_state",   32'(dbg_state), 32'(ST_EXEC));
    check("rd_re_exec_en", 32'(exec_en),   32'h1);
    check("rd_re_instr",   32'(instr),     32'hC00);
    run = 1'b0;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
